// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, receiver state enum and baud divisor helpers
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int          DIV_W      = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  // Baud rate in bits per second for each baud_select code
  function automatic int unsigned baud_rate(input logic [2:0] code);
    case (code)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // clk cycles per oversample tick, rounded to nearest
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz, input logic [2:0] code);
    int unsigned b;
    b = baud_rate(code);
    return DIV_W'((clk_hz + (OVERSAMPLE / 2) * b) / (OVERSAMPLE * b));
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - 16x oversample tick generator with baud latched on restart
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [2:0] baud_select,
  output logic       tick
);

  logic [2:0]       baud_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;

  assign div = baud_div(CLK_HZ, baud_q);

  // Divider counter; restart realigns the tick phase to the start edge and captures the baud
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      baud_q <= 3'd0;
      tick   <= 1'b0;
    end else if (restart) begin
      cnt    <= '0;
      baud_q <= baud_select;
      tick   <= 1'b0;
    end else if (cnt == div - DIV_W'(1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int          DATA_BITS   = 8,
  parameter int          PARITY_MODE = 2,
  parameter int          STOP_BITS   = 1,
  parameter int unsigned CLK_HZ      = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_FERROR,
  output logic                 Rx_PERROR,
  output logic                 Rx_BUSY
);

  rx_state_t            state;
  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 tick;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_res;
  logic                 ferr_res;
  logic                 start_det;
  logic                 sample_now;
  logic                 bit_val;
  logic                 par_exp;
  logic                 ferr_final;

  assign rx_s      = rx_sync[1];
  assign start_det = (state == ST_IDLE) && Rx_EN && rx_prev && !rx_s;
  assign Rx_BUSY   = (state != ST_IDLE);

  // Line synchroniser plus one extra stage for falling-edge detection; idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], RxD};
      rx_prev <= rx_s;
    end
  end

  uart_rx_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk         (clk),
    .reset       (reset),
    .restart     (start_det),
    .baud_select (baud_select),
    .tick        (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_TICK = 4'd8;
  logic s6, s7;

  // Hold the tick-6 and tick-7 samples so the vote completes with the tick-8 sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s6 <= 1'b1;
      s7 <= 1'b1;
    end else if (tick) begin
      if (tick_cnt == 4'd6) s6 <= rx_s;
      if (tick_cnt == 4'd7) s7 <= rx_s;
    end
  end

  assign bit_val = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);
`else
  localparam logic [3:0] DECIDE_TICK = 4'd7;
  assign bit_val = rx_s;
`endif

  assign sample_now = tick && (tick_cnt == DECIDE_TICK);
  assign par_exp    = (PARITY_MODE == PARITY_EVEN) ? ^shreg : ~^shreg;
  assign ferr_final = ferr_res | ~bit_val;

  // Frame FSM: every decision happens at a bit's sample point, the tick counter keeps bit phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= 4'd0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      perr_res  <= 1'b0;
      ferr_res  <= 1'b0;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_FERROR <= 1'b0;
      Rx_PERROR <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      if (state != ST_IDLE && !Rx_EN) begin
        state    <= ST_IDLE;
        tick_cnt <= 4'd0;
      end else begin
        if (tick) tick_cnt <= tick_cnt + 4'd1;
        case (state)
          ST_IDLE: begin
            if (start_det) begin
              state    <= ST_START;
              tick_cnt <= 4'd0;
            end
          end
          ST_START: begin
            if (sample_now) begin
              if (bit_val) begin
                state <= ST_IDLE;
              end else begin
                state     <= ST_DATA;
                bit_idx   <= 3'd0;
                perr_res  <= 1'b0;
                ferr_res  <= 1'b0;
                Rx_FERROR <= 1'b0;
                Rx_PERROR <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            if (sample_now) begin
              shreg <= {bit_val, shreg[DATA_BITS-1:1]};
              if (bit_idx == 3'(DATA_BITS - 1)) begin
                state    <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                stop_idx <= 1'b0;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
          ST_PARITY: begin
            if (sample_now) begin
              perr_res <= (bit_val != par_exp);
              state    <= ST_STOP;
              stop_idx <= 1'b0;
            end
          end
          ST_STOP: begin
            if (sample_now) begin
              if (stop_idx == 1'(STOP_BITS - 1)) begin
                Rx_DATA   <= shreg;
                Rx_FERROR <= ferr_final;
                Rx_PERROR <= perr_res;
                Rx_VALID  <= !ferr_final && !perr_res;
                state     <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
              end else begin
                ferr_res <= ferr_final;
                stop_idx <= 1'b1;
              end
            end
          end
          ST_WAIT_HIGH: begin
            if (rx_s) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param (default and 7N2 configurations)
module tb_uart_rx_param;

  localparam int BIT7 = 16 * 27;   // 115200 baud at 50 MHz
  localparam int BIT6 = 16 * 54;   // 57600 baud at 50 MHz

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_a, baud_b;
  logic       en_a, en_b;
  logic       rxd_a, rxd_b;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic       rx_valid_a, rx_ferror_a, rx_perror_a, rx_busy_a;
  logic       rx_valid_b, rx_ferror_b, rx_perror_b, rx_busy_b;

  int   checks = 0;
  int   errors = 0;
  int   frames_a = 0, frames_b = 0;
  int   pushed_a = 0, pushed_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  logic evt_a, evt_b, evt_prev_a, evt_prev_b, vchk_a, vchk_b;
  logic [7:0] break_d;

  always #5 clk = ~clk;

  uart_rx_param u_dut_a (
    .clk(clk), .reset(reset), .baud_select(baud_a), .Rx_EN(en_a), .RxD(rxd_a),
    .Rx_DATA(rx_data_a), .Rx_VALID(rx_valid_a), .Rx_FERROR(rx_ferror_a),
    .Rx_PERROR(rx_perror_a), .Rx_BUSY(rx_busy_a)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .reset(reset), .baud_select(baud_b), .Rx_EN(en_b), .RxD(rxd_b),
    .Rx_DATA(rx_data_b), .Rx_VALID(rx_valid_b), .Rx_FERROR(rx_ferror_b),
    .Rx_PERROR(rx_perror_b), .Rx_BUSY(rx_busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  task automatic send(input int which, input logic [7:0] data, input int nd, input bit has_par,
                      input logic par, input int nstop, input logic stop_v, input int cyc,
                      input logic final_v, input int gap_cyc);
    set_line(which, 1'b0);
    wait_cyc(cyc);
    for (int i = 0; i < nd; i++) begin
      set_line(which, data[i]);
      wait_cyc(cyc);
    end
    if (has_par) begin
      set_line(which, par);
      wait_cyc(cyc);
    end
    for (int i = 0; i < nstop; i++) begin
      set_line(which, stop_v);
      wait_cyc(cyc);
    end
    set_line(which, final_v);
    wait_cyc(gap_cyc);
  endtask

  task automatic push_a(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.data = d; e.perr = perr; e.ferr = ferr; e.valid = !perr && !ferr;
    q_a.push_back(e);
    pushed_a++;
  endtask

  task automatic push_b(input logic [7:0] d);
    exp_t e;
    e.data = d & 8'h7F; e.perr = 1'b0; e.ferr = 1'b0; e.valid = 1'b1;
    q_b.push_back(e);
    pushed_b++;
  endtask

  assign evt_a = rx_valid_a | rx_ferror_a | rx_perror_a;
  assign evt_b = rx_valid_b | rx_ferror_b | rx_perror_b;

  // Monitor A: each completed frame shows as a VALID pulse or a freshly raised error flag
  always @(negedge clk) begin
    if (reset) begin
      evt_prev_a <= 1'b0;
      vchk_a     <= 1'b0;
    end else begin
      if (vchk_a) check("valid_pulse_width_a", 32'(rx_valid_a), 32'd0);
      vchk_a <= rx_valid_a;
      if (evt_a && !evt_prev_a) begin
        frames_a++;
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_a: got data %0h with no frame expected", rx_data_a);
        end else begin
          ea = q_a.pop_front();
          check("rx_data_a", 32'(rx_data_a), 32'(ea.data));
          check("rx_valid_a", 32'(rx_valid_a), 32'(ea.valid));
          check("rx_perror_a", 32'(rx_perror_a), 32'(ea.perr));
          check("rx_ferror_a", 32'(rx_ferror_a), 32'(ea.ferr));
        end
      end
      evt_prev_a <= evt_a;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (reset) begin
      evt_prev_b <= 1'b0;
      vchk_b     <= 1'b0;
    end else begin
      if (vchk_b) check("valid_pulse_width_b", 32'(rx_valid_b), 32'd0);
      vchk_b <= rx_valid_b;
      if (evt_b && !evt_prev_b) begin
        frames_b++;
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_b: got data %0h with no frame expected", rx_data_b);
        end else begin
          eb = q_b.pop_front();
          check("rx_data_b", 32'(rx_data_b), 32'(eb.data));
          check("rx_valid_b", 32'(rx_valid_b), 32'(eb.valid));
          check("rx_perror_b", 32'(rx_perror_b), 32'(eb.perr));
          check("rx_ferror_b", 32'(rx_ferror_b), 32'(eb.ferr));
        end
      end
      evt_prev_b <= evt_b;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data_a"}, 32'(rx_data_a), 32'd0);
    check({tag, "_valid_a"}, 32'(rx_valid_a), 32'd0);
    check({tag, "_ferror_a"}, 32'(rx_ferror_a), 32'd0);
    check({tag, "_perror_a"}, 32'(rx_perror_a), 32'd0);
    check({tag, "_busy_a"}, 32'(rx_busy_a), 32'd0);
    check({tag, "_data_b"}, 32'(rx_data_b), 32'd0);
    check({tag, "_valid_b"}, 32'(rx_valid_b), 32'd0);
    check({tag, "_busy_b"}, 32'(rx_busy_b), 32'd0);
  endtask

  task automatic run_a();
    logic [7:0] d;
    logic       bad;
    push_a(8'hA5, 1'b0, 1'b0);
    send(0, 8'hA5, 8, 1, 1'b1, 1, 1'b1, BIT7, 1'b1, 0);
    push_a(8'hA5, 1'b1, 1'b0);
    send(0, 8'hA5, 8, 1, 1'b0, 1, 1'b1, BIT7, 1'b1, BIT7);
    d = 8'($urandom);
    push_a(d, 1'b0, 1'b0);
    send(0, d, 8, 1, odd_par(d), 1, 1'b1, BIT7, 1'b1, 0);
    for (int i = 0; i < 2; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 2) == 0);
      push_a(d, bad, 1'b0);
      send(0, d, 8, 1, odd_par(d) ^ bad, 1, 1'b1, BIT7, 1'b1, $urandom_range(0, 1) * BIT7);
    end
    baud_a = 3'd6;
    wait_cyc(4);
    d = 8'($urandom);
    push_a(d, 1'b0, 1'b0);
    fork
      send(0, d, 8, 1, odd_par(d), 1, 1'b1, BIT6, 1'b1, BIT7);
      begin
        wait_cyc(2000);
        baud_a = 3'd7;
      end
    join
    break_d = 8'($urandom);
    push_a(break_d, 1'b0, 1'b1);
    send(0, break_d, 8, 1, odd_par(break_d), 1, 1'b0, BIT7, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      wait_cyc(10 * BIT7);
      check("busy_during_break_a", 32'(rx_busy_a), 32'd1);
    end
    rxd_a = 1'b1;
    wait_cyc(2 * BIT7);
    check("busy_after_break_a", 32'(rx_busy_a), 32'd0);
    check("ferror_held_a", 32'(rx_ferror_a), 32'd1);
    check("frames_after_break_a", 32'(frames_a), 32'(pushed_a));
    rxd_a = 1'b0;
    wait_cyc(2 * 27);
    rxd_a = 1'b1;
    wait_cyc(2 * BIT7);
    check("glitch_busy_a", 32'(rx_busy_a), 32'd0);
    check("glitch_data_a", 32'(rx_data_a), 32'(break_d));
    check("glitch_ferror_a", 32'(rx_ferror_a), 32'd1);
    check("glitch_perror_a", 32'(rx_perror_a), 32'd0);
    check("glitch_frames_a", 32'(frames_a), 32'(pushed_a));
  endtask

  task automatic run_b();
    logic [7:0] d;
    push_b(8'h41);
    send(1, 8'h41, 7, 0, 1'b0, 2, 1'b1, BIT7, 1'b1, 0);
    push_b(8'h7F);
    send(1, 8'h7F, 7, 0, 1'b0, 2, 1'b1, BIT7, 1'b1, BIT7);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 127));
      push_b(d);
      send(1, d, 7, 0, 1'b0, 2, 1'b1, BIT7, 1'b1, $urandom_range(0, 1) * BIT7);
    end
  endtask

  initial begin
    reset  = 1'b1;
    rxd_a  = 1'b1; rxd_b  = 1'b1;
    en_a   = 1'b1; en_b   = 1'b1;
    baud_a = 3'd7; baud_b = 3'd7;
    wait_cyc(5);
    check_all_zero("reset");
    reset = 1'b0;
    wait_cyc(5);

    fork
      run_a();
      run_b();
    join

    fork
      send(0, 8'hFF, 8, 1, odd_par(8'hFF), 1, 1'b1, BIT7, 1'b1, BIT7);
      begin
        wait_cyc(1900);
        check("busy_before_reset_a", 32'(rx_busy_a), 32'd1);
        reset = 1'b1;
        en_a  = 1'b0;
        wait_cyc(3);
        check_all_zero("midframe_reset");
        reset = 1'b0;
        wait_cyc(2);
        en_a = 1'b1;
      end
    join
    check("post_reset_busy_a", 32'(rx_busy_a), 32'd0);

    fork
      send(0, 8'h3C, 8, 1, odd_par(8'h3C), 1, 1'b1, BIT7, 1'b1, BIT7);
      begin
        wait_cyc(1900);
        check("busy_before_abort_a", 32'(rx_busy_a), 32'd1);
        en_a = 1'b0;
        wait_cyc(2);
        check("busy_after_abort_a", 32'(rx_busy_a), 32'd0);
      end
    join
    en_a = 1'b1;
    wait_cyc(BIT7);
    check("abort_data_a", 32'(rx_data_a), 32'd0);
    check("abort_ferror_a", 32'(rx_ferror_a), 32'd0);
    check("abort_perror_a", 32'(rx_perror_a), 32'd0);
    check("abort_busy_a", 32'(rx_busy_a), 32'd0);

    check("queue_empty_a", 32'(q_a.size()), 32'd0);
    check("queue_empty_b", 32'(q_b.size()), 32'd0);
    check("frame_count_a", 32'(frames_a), 32'(pushed_a));
    check("frame_count_b", 32'(frames_b), 32'(pushed_b));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
